// File: rtl/fixed_point_alu_iter_if.sv
// fixed_point_alu_iter_if: start/done handshake bundle for the ALU.
// master drives start/operation/operands; slave returns result+flags.
interface fixed_point_alu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       operation;
  logic [WIDTH-1:0] operand_1;
  logic [WIDTH-1:0] operand_2;
  logic [WIDTH-1:0] result;
  logic             ready;
  logic             done;
  logic             overflow;
  logic             error;

  modport master (
    output start, operation, operand_1, operand_2,
    input  result, ready, done, overflow, error
  );

  modport slave (
    input  start, operation, operand_1, operand_2,
    output result, ready, done, overflow, error
  );
endinterface

// File: rtl/fixed_point_alu_iter.sv
// fixed_point_alu_iter: iterative signed Qm.FBITS add/sub/mul/div/sqrt.
// Ports: clk, reset (async, active-low), bus (slave handshake/result).
module fixed_point_alu_iter #(
  parameter int WIDTH = 32,
  parameter int FBITS = 10,
  parameter bit SAT   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  fixed_point_alu_iter_if.slave bus
);
  localparam int DW = WIDTH + FBITS;
  localparam int SN = (DW + 1) / 2;
  localparam int SW = 2 * SN;
  localparam int MW = 2 * WIDTH;
  localparam int CW = $clog2(DW + 1);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_SQRT = 3'd4;

  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [MW-1:0] MAX_MAG = {{(MW-WIDTH){1'b0}}, MAXV};
  localparam logic [MW-1:0] MIN_MAG = {{(MW-WIDTH){1'b0}}, MINV};

  localparam logic [CW-1:0] MUL_L = CW'(WIDTH - 1);
  localparam logic [CW-1:0] DIV_L = CW'(DW - 1);
  localparam logic [CW-1:0] SQ_L  = CW'(SN - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ov_q, ov_d;
  logic             err_q, err_d;
  logic [MW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [MW-1:0]    prod_q, prod_d;
  logic [DW-1:0]    dq_q, dq_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [SW-1:0]    rad_q, rad_d;
  logic [SN-1:0]    root_q, root_d;
  logic [SN+1:0]    srem_q, srem_d;

  logic [2:0]       op;
  logic             a_neg, b_neg, b_zero;
  logic             is_as, is_mul, is_div;
  logic             is_sqrt, is_bad, accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   a_ext, b_ext, sum;
  logic             add_ov;
  logic [WIDTH-1:0] add_res;

  assign op      = bus.operation;
  assign a_neg   = bus.operand_1[WIDTH-1];
  assign b_neg   = bus.operand_2[WIDTH-1];
  assign b_zero  = (bus.operand_2 == '0);
  assign is_as   = (op == OP_ADD) || (op == OP_SUB);
  assign is_mul  = (op == OP_MUL);
  assign is_div  = (op == OP_DIV);
  assign is_sqrt = (op == OP_SQRT);
  assign is_bad  = (op > OP_SQRT);
  assign accept  = bus.start && (state_q != CALC);

  // |MIN| = 2^(WIDTH-1) still fits as an unsigned WIDTH-bit magnitude.
  assign a_mag = a_neg ? -bus.operand_1 : bus.operand_1;
  assign b_mag = b_neg ? -bus.operand_2 : bus.operand_2;

  assign a_ext  = {a_neg, bus.operand_1};
  assign b_ext  = {b_neg, bus.operand_2};
  assign sum    = (op == OP_SUB) ? a_ext - b_ext
                                 : a_ext + b_ext;
  assign add_ov = sum[WIDTH] ^ sum[WIDTH-1];
  assign add_res = (add_ov && SAT)
                 ? (sum[WIDTH] ? MINV : MAXV)
                 : sum[WIDTH-1:0];

  logic [MW-1:0]    prod_n;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] rem_n;
  logic [DW-1:0]    dq_n;
  logic [SN+3:0]    sq_sh, sq_trial;
  logic             sq_ge;
  logic [SN+1:0]    srem_n;
  logic [SN-1:0]    root_n;

  assign prod_n = b_q[0] ? prod_q + mcand_q : prod_q;

  // dq_q shifts dividend bits out the top and quotient bits in below.
  assign rem_sh = {rem_q, dq_q[DW-1]};
  assign div_ge = rem_sh >= {1'b0, b_q};
  assign rem_n  = div_ge ? WIDTH'(rem_sh - {1'b0, b_q})
                         : rem_sh[WIDTH-1:0];
  assign dq_n   = {dq_q[DW-2:0], div_ge};

  assign sq_sh    = {srem_q, rad_q[SW-1 -: 2]};
  assign sq_trial = {2'b00, root_q, 2'b01};
  assign sq_ge    = sq_sh >= sq_trial;
  assign srem_n   = sq_ge ? (SN+2)'(sq_sh - sq_trial)
                          : sq_sh[SN+1:0];
  assign root_n   = {root_q[SN-2:0], sq_ge};

  logic [CW-1:0]    n_last;
  logic [MW-1:0]    fin_mag;
  logic             fin_neg, fin_ov;
  logic [WIDTH-1:0] fin_low, fin_res;

  assign n_last = (op_q == OP_MUL) ? MUL_L
                : (op_q == OP_DIV) ? DIV_L : SQ_L;

  // Finalise from the last iteration's next values so the
  // closing iteration and the DONE entry share one edge.
  always_comb begin
    fin_mag = '0;
    fin_neg = 1'b0;
    unique case (1'b1)
      op_q == OP_MUL: begin
        fin_mag = prod_n >> FBITS;
        fin_neg = neg_q;
      end
      op_q == OP_DIV: begin
        fin_mag = MW'(dq_n);
        fin_neg = neg_q;
      end
      default: fin_mag = MW'(root_n);
    endcase
  end

  assign fin_low = fin_mag[WIDTH-1:0];
  assign fin_ov  = fin_neg ? (fin_mag > MIN_MAG)
                           : (fin_mag > MAX_MAG);
  assign fin_res = (fin_ov && SAT)
                 ? (fin_neg ? MINV : MAXV)
                 : (fin_neg ? -fin_low : fin_low);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ov_d    = ov_q;
    err_d   = err_q;
    mcand_d = mcand_q;
    b_d     = b_q;
    prod_d  = prod_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    rad_d   = rad_q;
    root_d  = root_q;
    srem_d  = srem_q;

    if (state_q == DONE) state_d = IDLE;

    if (state_q == CALC) begin
      cnt_d  = cnt_q + 1'b1;
      dq_d   = dq_n;
      rem_d  = rem_n;
      rad_d  = rad_q << 2;
      root_d = root_n;
      srem_d = srem_n;
      if (op_q == OP_MUL) begin
        prod_d  = prod_n;
        mcand_d = mcand_q << 1;
        b_d     = b_q >> 1;
      end
      if (cnt_q == n_last) begin
        state_d = DONE;
        cnt_d   = '0;
        res_d   = fin_res;
        ov_d    = fin_ov;
        err_d   = 1'b0;
      end
    end else if (accept) begin
      state_d = CALC;
      op_d    = op;
      neg_d   = a_neg ^ b_neg;
      cnt_d   = '0;
      mcand_d = MW'(a_mag);
      b_d     = b_mag;
      prod_d  = '0;
      dq_d    = {a_mag, {FBITS{1'b0}}};
      rem_d   = '0;
      rad_d   = SW'({bus.operand_1, {FBITS{1'b0}}});
      root_d  = '0;
      srem_d  = '0;
      unique case (1'b1)
        is_as: begin
          state_d = DONE;
          res_d   = add_res;
          ov_d    = add_ov;
          err_d   = 1'b0;
        end
        is_div && b_zero: begin
          state_d = DONE;
          res_d   = a_neg ? MINV : MAXV;
          ov_d    = 1'b0;
          err_d   = 1'b1;
        end
        (is_sqrt && a_neg) || is_bad: begin
          state_d = DONE;
          res_d   = '0;
          ov_d    = 1'b0;
          err_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
      mcand_q <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      dq_q    <= '0;
      rem_q   <= '0;
      rad_q   <= '0;
      root_q  <= '0;
      srem_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
      mcand_q <= mcand_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      dq_q    <= dq_d;
      rem_q   <= rem_d;
      rad_q   <= rad_d;
      root_q  <= root_d;
      srem_q  <= srem_d;
    end
  end

  assign bus.result   = res_q;
  assign bus.ready    = (state_q != CALC);
  assign bus.done     = (state_q == DONE);
  assign bus.overflow = ov_q;
  assign bus.error    = err_q;
endmodule

// File: tb/tb_fixed_point_alu_iter.sv
// tb_fixed_point_alu_iter: scoreboard bench for the iterative ALU.
// Two instances: saturating (main) and wrapping (add/sub only).
module tb_fixed_point_alu_iter;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc    = 0;
  int   total  = 0;
  int   bad    = 0;
  int   n_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fixed_point_alu_iter_if #(.WIDTH(W)) b1 ();
  fixed_point_alu_iter_if #(.WIDTH(W)) b0 ();

  fixed_point_alu_iter #(
    .WIDTH(W), .FBITS(10), .SAT(1'b1)
  ) dut (
    .clk(clk), .reset(rst_n), .bus(b1)
  );

  fixed_point_alu_iter #(
    .WIDTH(W), .FBITS(10), .SAT(1'b0)
  ) dut_w (
    .clk(clk), .reset(rst_n), .bus(b0)
  );

  typedef struct {
    logic [63:0] tag;
    logic [31:0] res;
    logic        ov;
    logic        err;
    int          lat;
    int          t0;
  } exp_t;

  exp_t q[$];

  task automatic chk(input logic [63:0] tag,
                     input string sub,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s/%s got=%h want=%h",
             tag, sub, got, want);
    end
  endtask

  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (b1.done === 1'b1) begin
        n_done++;
        if (q.size() == 0) begin
          chk("spur", "done", 32'(b1.done), 32'd0);
        end else begin
          e = q.pop_front();
          chk(e.tag, "res", b1.result, e.res);
          chk(e.tag, "ov", 32'(b1.overflow), 32'(e.ov));
          chk(e.tag, "err", 32'(b1.error), 32'(e.err));
          chk(e.tag, "lat", 32'(cyc - e.t0), 32'(e.lat));
        end
      end
    end
  end

  // Called at a negedge; leaves start high across one rising edge.
  task automatic issue(input logic [63:0] tag,
                       input logic [2:0]  op,
                       input logic [31:0] a,
                       input logic [31:0] bb,
                       input logic [31:0] er,
                       input logic        eo,
                       input logic        ee,
                       input int          lat,
                       input bit          push);
    exp_t e;
    b1.operation = op;
    b1.operand_1 = a;
    b1.operand_2 = bb;
    b1.start     = 1'b1;
    if (push) begin
      e.tag = tag; e.res = er; e.ov = eo;
      e.err = ee;  e.lat = lat; e.t0 = cyc;
      q.push_back(e);
    end
    @(negedge clk);
    b1.start     = 1'b0;
    b1.operand_1 = $urandom;
    b1.operand_2 = $urandom;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain", "tmo", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wchk(input logic [63:0] tag,
                      input logic [2:0]  op,
                      input logic [31:0] a,
                      input logic [31:0] bb,
                      input logic [31:0] er);
    b0.operation = op;
    b0.operand_1 = a;
    b0.operand_2 = bb;
    b0.start     = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    chk(tag, "done", 32'(b0.done), 32'd1);
    chk(tag, "res", b0.result, er);
    chk(tag, "ov", 32'(b0.overflow), 32'd1);
    @(negedge clk);
  endtask

  initial begin : stim
    int n;
    int nd;
    b1.start = 1'b0; b1.operation = 3'd0;
    b1.operand_1 = '0; b1.operand_2 = '0;
    b0.start = 1'b0; b0.operation = 3'd0;
    b0.operand_1 = '0; b0.operand_2 = '0;

    repeat (3) @(negedge clk);
    chk("rst", "res", b1.result, 32'd0);
    chk("rst", "rdy", 32'(b1.ready), 32'd1);
    chk("rst", "done", 32'(b1.done), 32'd0);
    chk("rst", "ov", 32'(b1.overflow), 32'd0);
    chk("rst", "err", 32'(b1.error), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue("mul1", 3'd2, 32'h0000_0600, 32'h0000_0800,
          32'h0000_0C00, 0, 0, 33, 1);
    drain(100);
    issue("mul2", 3'd2, 32'hFFFF_FA00, 32'h0000_0800,
          32'hFFFF_F400, 0, 0, 33, 1);
    drain(100);
    issue("mulovp", 3'd2, 32'h0100_0000, 32'h0010_0000,
          32'h7FFF_FFFF, 1, 0, 33, 1);
    drain(100);
    issue("mulovn", 3'd2, 32'hFF00_0000, 32'h0010_0000,
          32'h8000_0000, 1, 0, 33, 1);
    drain(100);
    issue("mulminn", 3'd2, 32'hFFE0_0000, 32'h0010_0000,
          32'h8000_0000, 0, 0, 33, 1);
    drain(100);
    issue("mulmaxp", 3'd2, 32'h0020_0000, 32'h0010_0000,
          32'h7FFF_FFFF, 1, 0, 33, 1);
    drain(100);

    issue("div1", 3'd3, 32'h0000_0C00, 32'h0000_0800,
          32'h0000_0600, 0, 0, 43, 1);
    drain(100);
    issue("div3", 3'd3, 32'h0000_0400, 32'h0000_0C00,
          32'h0000_0155, 0, 0, 43, 1);
    drain(100);
    issue("div3n", 3'd3, 32'hFFFF_FC00, 32'h0000_0C00,
          32'hFFFF_FEAB, 0, 0, 43, 1);
    drain(100);
    issue("div3nb", 3'd3, 32'h0000_0400, 32'hFFFF_F400,
          32'hFFFF_FEAB, 0, 0, 43, 1);
    drain(100);
    issue("divov", 3'd3, 32'h7FFF_FFFF, 32'h0000_0001,
          32'h7FFF_FFFF, 1, 0, 43, 1);
    drain(100);
    issue("div0p", 3'd3, 32'h0000_0400, 32'h0000_0000,
          32'h7FFF_FFFF, 0, 1, 1, 1);
    drain(100);
    issue("div0n", 3'd3, 32'hFFFF_FC00, 32'h0000_0000,
          32'h8000_0000, 0, 1, 1, 1);
    drain(100);

    issue("sqrt4", 3'd4, 32'h0000_1000, 32'h1234_5678,
          32'h0000_0800, 0, 0, 22, 1);
    drain(100);
    issue("sqrt2", 3'd4, 32'h0000_0800, 32'h0,
          32'h0000_05A8, 0, 0, 22, 1);
    drain(100);
    issue("sqrtn", 3'd4, 32'h8000_0000, 32'h0,
          32'h0000_0000, 0, 1, 1, 1);
    drain(100);

    issue("addsat", 3'd0, 32'h7FFF_FFFF, 32'h0000_0001,
          32'h7FFF_FFFF, 1, 0, 1, 1);
    drain(100);
    issue("subsat", 3'd1, 32'h8000_0000, 32'h0000_0001,
          32'h8000_0000, 1, 0, 1, 1);
    drain(100);
    issue("illegal", 3'd6, 32'h0000_0400, 32'h0000_0400,
          32'h0000_0000, 0, 1, 1, 1);
    drain(100);

    wchk("addwrap", 3'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
    wchk("subwrap", 3'd1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF);

    issue("b2bmul", 3'd2, 32'h0000_0600, 32'h0000_0800,
          32'h0000_0C00, 0, 0, 33, 1);
    n = 0;
    while (b1.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    issue("b2bsub", 3'd1, 32'h0000_1000, 32'h0000_0400,
          32'h0000_0C00, 0, 0, 1, 1);
    drain(100);

    issue("ignmul", 3'd2, 32'h0000_0C00, 32'h0000_0C00,
          32'h0000_2400, 0, 0, 33, 1);
    repeat (5) @(negedge clk);
    issue("ignadd", 3'd0, 32'h1, 32'h1, 32'h2, 0, 0, 1, 0);
    drain(100);

    issue("rstdiv", 3'd3, 32'h0000_0C00, 32'h0000_0800,
          32'h0000_0600, 0, 0, 43, 0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst", "res", b1.result, 32'd0);
    chk("midrst", "rdy", 32'(b1.ready), 32'd1);
    chk("midrst", "done", 32'(b1.done), 32'd0);
    chk("midrst", "ov", 32'(b1.overflow), 32'd0);
    chk("midrst", "err", 32'(b1.error), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = n_done;
    issue("postrst", 3'd0, 32'h0000_0400, 32'h0000_0400,
          32'h0000_0800, 0, 0, 1, 1);
    drain(100);
    repeat (50) @(negedge clk);
    chk("nodone", "cnt", 32'(n_done), 32'(nd + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fixed_point_alu_iter.md
# fixed_point_alu_iter

Parametrised, multi-cycle signed fixed-point arithmetic unit for the execute stage. It supersedes the single-shot add/sub/mul/sqrt unit: iterative shift-add multiply, restoring divide and digit-by-digit square root share one control FSM behind a start/done handshake. It adds saturation and error flags. Operands and result use signed two's-complement Q(WIDTH-FBITS).FBITS format.

## Interface
- WIDTH, 32: operand and result width in bits (≥ 8).
- FBITS, 10: fractional bits (1 ≤ FBITS < WIDTH).
- SAT, 1: 1 = saturate on overflow; 0 = wrap (truncate to WIDTH).
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  request; accepted only while ready=1.
- operation  in  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 SQRT; 101–111 illegal.
- operand_1  in  WIDTH  A (dividend / radicand).
- operand_2  in  WIDTH  B (divisor; ignored for SQRT).
- result  out  WIDTH  registered result; held until the next done.
- ready  out  1  unit can accept start.
- done  out  1  one-cycle pulse; result and flags are valid in this cycle.
- overflow  out  1  result saturated or wrapped; valid with done.
- error  out  1  divide by zero, negative radicand or illegal op; valid with done.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE: ready=1. start=1 captures operation and operands, clears the iteration counter. ADD/SUB/illegal/error cases go to DONE; all others go to CALC.
  - CALC: ready=0. One iteration per cycle. Go to DONE when the counter reaches N-1.
  - DONE: done=1, ready=1. Go back to IDLE, or start a new operation if start=1. This allows back-to-back operations with no bubble.
- start while ready=0 is ignored; no queuing.
- ADD/SUB: compute in WIDTH+1 bits. On signed overflow, overflow=1 and the result is 2^(WIDTH-1)-1 or -2^(WIDTH-1) if SAT, else the low WIDTH bits.
- MUL: multiply magnitudes with shift-add, N=WIDTH iterations, 2·WIDTH-bit accumulator. Take the product >> FBITS (magnitude truncation, i.e. round toward zero), then apply the sign (A xor B).
  - Magnitude > 2^(WIDTH-1)-1 for a positive result, or > 2^(WIDTH-1) for a negative one, sets overflow and is handled as in ADD.
- DIV: restoring division of |A|<<FBITS by |B|, N=WIDTH+FBITS iterations. Quotient truncated toward zero, then the sign is applied; overflow is handled as in MUL.
  - B=0: no iterations, error=1, result = max positive if A≥0 else min negative, overflow=0.
- SQRT: digit-by-digit integer root of A<<FBITS, zero-extended by one bit if WIDTH+FBITS is odd. N=ceil((WIDTH+FBITS)/2) iterations. The result is non-negative and never overflows.
  - A<0: no iterations, error=1, result=0.
- Illegal op: error=1, result=0, overflow=0.
- overflow and error are registered, updated only on entry to DONE, and held with result.

## Timing
- Reset values: result=0, ready=1, done=0, overflow=0, error=0, FSM=IDLE, counter=0.
- Latency from the start-accept edge to done=1:
  - ADD/SUB/error/illegal: 1 cycle.
  - MUL: WIDTH+1 cycles (33 at defaults).
  - DIV: WIDTH+FBITS+1 cycles (43).
  - SQRT: ceil((WIDTH+FBITS)/2)+1 cycles (22).
- Throughput: one operation per latency period. In DONE, a start on the same edge begins the next operation.
- Operands may change freely after the accept edge.
- Reset asserted mid-operation: abort immediately, and no done pulse follows. On reset release the unit is in IDLE and ready on the first rising edge.

## Test plan
- MUL 0x00000600 × 0x00000800 (1.5×2.0) -> done at cycle 33, result 0x00000C00, flags 0. Repeat with A=0xFFFFFA00 -> result 0xFFFFF400.
- DIV 0x00000C00 / 0x00000800 -> done at cycle 43, result 0x00000600. DIV 0x00000400 / 0 -> done at cycle 1, result 0x7FFFFFFF, error=1.
- SQRT 0x00001000 (4.0) -> done at cycle 22, result 0x00000800. SQRT 0x80000000 -> done at cycle 1, result 0, error=1.
- ADD 0x7FFFFFFF + 0x00000001: SAT=1 -> 0x7FFFFFFF, overflow=1; SAT=0 -> 0x80000000, overflow=1.
- Back-to-back: start SUB held high in the DONE cycle of a MUL -> SUB done exactly 1 cycle later. A start pulsed during CALC is ignored, with no extra done.
- Reset=0 at cycle 10 of a DIV -> all outputs at reset values, no done. After release, ADD 0x400+0x400 -> 0x800 at cycle 1.
